// File: rtl/hs_issue_pkg.sv
// -----------------------------------------------------------------------------
// hs_issue_pkg
// Shared types and helpers for the handshake issue arbiter.
//   state_t : controller states (IDLE, SETUP, WAIT, ERR)
//   clog2w  : index width for a count of n items, never less than 1
// -----------------------------------------------------------------------------
package hs_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    function automatic int clog2w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/hs_issue_arbiter_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous level/phase signal.
//   i_clk : destination clock
//   i_rst : asynchronous reset, active-high, clears both flops to 0
//   i_d   : asynchronous input
//   o_q   : synchronized output, two i_clk edges behind i_d
// -----------------------------------------------------------------------------
module sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/hs_issue_arbiter.sv
// -----------------------------------------------------------------------------
// hs_issue_arbiter
// Shares one 2-phase bundled-data handshake pipeline between NREQ clocked
// requesters. A round-robin pick accepts one token, freezes it on data_out,
// waits SETUP_CYC cycles, toggles req_out and then waits for the synchronized
// ack phase to equal req_out. A missing ack after TIMEOUT cycles parks the
// controller in a terminal error state until reset.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active-high
//   src_valid  in   [NREQ]    requester i has a token
//   src_data   in   [NREQ*W]  token data, requester i at [i*W +: W]
//   src_ready  out  [NREQ]    one-hot acceptance strobe (combinational)
//   req_out    out            2-phase request to pipeline (registered)
//   ack_in     in             2-phase acknowledge, asynchronous to clk
//   data_out   out  [W]       bundled data to pipeline (registered)
//   grant_id   out  [GW]      requester owning the current token
//   busy       out            high in SETUP or WAIT
//   err        out            sticky handshake timeout flag
//   tx_count   out  [CNTW]    completed tokens, wraps
// -----------------------------------------------------------------------------
module hs_issue_arbiter
    import hs_issue_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int W         = 3,
    parameter int SETUP_CYC = 1,
    parameter int TIMEOUT   = 255,
    parameter int CNTW      = 16,
    localparam int GW       = clog2w(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   src_valid,
    input  logic [NREQ*W-1:0] src_data,
    output logic [NREQ-1:0]   src_ready,
    output logic              req_out,
    input  logic              ack_in,
    output logic [W-1:0]      data_out,
    output logic [GW-1:0]     grant_id,
    output logic              busy,
    output logic              err,
    output logic [CNTW-1:0]   tx_count
);

    localparam int SCW = 3;
    localparam int TCW = 16;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_req;
    logic [W-1:0]     r_data;
    logic [GW-1:0]    r_gid;
    logic [GW-1:0]    r_ptr;
    logic [SCW-1:0]   r_scnt;
    logic [TCW-1:0]   r_tcnt;
    logic             r_err;
    logic [CNTW-1:0]  r_cnt;

    logic             w_ack_s;
    logic             w_any;
    logic [GW-1:0]    w_pick;
    logic [NREQ-1:0]  w_src_ready;
    logic             w_accept;
    logic             w_toggle;
    logic             w_done;
    logic             w_tmo;
    logic [W-1:0]     w_sd [NREQ];

    sync2 u_ack_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (ack_in),
        .o_q   (w_ack_s)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_sd[gi] = src_data[gi*W +: W];
    end

    // Round-robin pick: scan offsets from the pointer downwards so that the
    // smallest circular distance from r_ptr is the one left standing.
    always_comb begin
        int            idx;
        logic [GW-1:0] w_idx;
        w_any  = 1'b0;
        w_pick = '0;
        idx    = 0;
        w_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            w_idx = GW'(idx);
            if (src_valid[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_ready = '0;
        w_accept    = 1'b0;
        w_toggle    = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_accept            = 1'b1;
                    w_src_ready[w_pick] = 1'b1;
                    w_state_nxt         = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_scnt == SCW'(SETUP_CYC - 1)) begin
                    w_toggle    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A match on the last allowed cycle still wins over timeout.
                if (w_ack_s == r_req) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_tcnt == TCW'(TIMEOUT - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req  <= 1'b0;
            r_data <= '0;
            r_gid  <= '0;
            r_ptr  <= '0;
            r_scnt <= '0;
            r_tcnt <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_data <= w_sd[w_pick];
                r_gid  <= w_pick;
                r_scnt <= '0;
            end
            if (r_state == ST_SETUP) r_scnt <= r_scnt + 1'b1;
            if (w_toggle) begin
                r_req  <= ~r_req;
                r_tcnt <= '0;
            end
            if (r_state == ST_WAIT) r_tcnt <= r_tcnt + 1'b1;
            if (w_done) begin
                r_cnt <= r_cnt + 1'b1;
                r_ptr <= (r_gid == GW'(NREQ - 1)) ? '0 : r_gid + 1'b1;
            end
            if (w_tmo) r_err <= 1'b1;
        end
    end

    assign src_ready = w_src_ready;
    assign req_out   = r_req;
    assign data_out  = r_data;
    assign grant_id  = r_gid;
    assign busy      = (r_state == ST_SETUP) || (r_state == ST_WAIT);
    assign err       = r_err;
    assign tx_count  = r_cnt;

endmodule

// File: tb/tb_hs_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hs_issue_arbiter
// Directed bench for hs_issue_arbiter. Instance A: NREQ=4, W=3, SETUP_CYC=1,
// TIMEOUT=10. Instance B: SETUP_CYC=3, CNTW=2 for the counter wrap case.
// Each instance has a pipeline model that echoes req_out onto ack_in three
// cycles later (A's echo can be switched off).
// -----------------------------------------------------------------------------
module tb_hs_issue_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  src_valid_a;
    logic [11:0] src_data_a;
    logic [3:0]  src_ready_a;
    logic        req_a;
    logic        ack_a = 1'b0;
    logic [2:0]  dout_a;
    logic [1:0]  gid_a;
    logic        busy_a;
    logic        err_a;
    logic [15:0] txc_a;

    logic [3:0]  src_valid_b;
    logic [11:0] src_data_b;
    logic [3:0]  src_ready_b;
    logic        req_b;
    logic        ack_b = 1'b0;
    logic [2:0]  dout_b;
    logic [1:0]  gid_b;
    logic        busy_b;
    logic        err_b;
    logic [1:0]  txc_b;

    logic [2:0]  dly_a = 3'b000;
    logic [2:0]  dly_b = 3'b000;
    logic        ack_en_a = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hs_issue_arbiter #(.NREQ(4), .W(3), .SETUP_CYC(1), .TIMEOUT(10), .CNTW(16)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid_a),
        .src_data  (src_data_a),
        .src_ready (src_ready_a),
        .req_out   (req_a),
        .ack_in    (ack_a),
        .data_out  (dout_a),
        .grant_id  (gid_a),
        .busy      (busy_a),
        .err       (err_a),
        .tx_count  (txc_a)
    );

    hs_issue_arbiter #(.NREQ(4), .W(3), .SETUP_CYC(3), .TIMEOUT(255), .CNTW(2)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid_b),
        .src_data  (src_data_b),
        .src_ready (src_ready_b),
        .req_out   (req_b),
        .ack_in    (ack_b),
        .data_out  (dout_b),
        .grant_id  (gid_b),
        .busy      (busy_b),
        .err       (err_b),
        .tx_count  (txc_b)
    );

    // Pipeline models: ack follows req three cycles later, driven mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            dly_a = 3'b000;
            ack_a = 1'b0;
            dly_b = 3'b000;
            ack_b = 1'b0;
        end else begin
            if (ack_en_a) begin
                dly_a = {dly_a[1:0], req_a};
                ack_a = dly_a[2];
            end
            dly_b = {dly_b[1:0], req_b};
            ack_b = dly_b[2];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One token on instance A with requesters already driven: wait for the
    // acceptance strobe, check the launch, then wait for the return to IDLE.
    task automatic token_a(input int idx, input logic [2:0] exp_d, input logic exp_req);
        int n;
        #1;
        n = 0;
        while (src_ready_a == 4'b0000 && n < 40) begin
            tick();
            n++;
        end
        check("tok_ready", 32'(src_ready_a), 32'(1 << idx));
        tick();
        check("tok_data", 32'(dout_a), 32'(exp_d));
        check("tok_gid", 32'(gid_a), 32'(idx));
        check("tok_busy", 32'(busy_a), 32'd1);
        tick();
        check("tok_req", 32'(req_a), 32'(exp_req));
        n = 0;
        while (busy_a && n < 40) begin
            tick();
            n++;
        end
        check("tok_idle", 32'(busy_a), 32'd0);
    endtask

    initial begin
        logic [2:0] d;
        logic       exp_req_b;
        int         n;

        rst         = 1'b1;
        src_valid_a = 4'b0000;
        src_data_a  = 12'h000;
        src_valid_b = 4'b0000;
        src_data_b  = 12'h000;
        repeat (2) tick();

        // Reset state
        check("rst_req", 32'(req_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_tx", 32'(txc_a), 32'd0);
        check("rst_dout", 32'(dout_a), 32'd0);
        check("rst_gid", 32'(gid_a), 32'd0);
        rst = 1'b0;
        tick();

        // Single requester 0, data 5, exact cycle timing
        src_valid_a = 4'b0001;
        src_data_a  = 12'b000_000_000_101;
        #1;
        check("single_ready", 32'(src_ready_a), 32'h1);
        tick();
        src_valid_a = 4'b0000;
        check("single_ready_off", 32'(src_ready_a), 32'h0);
        check("single_dout", 32'(dout_a), 32'd5);
        check("single_req_pre", 32'(req_a), 32'd0);
        check("single_busy", 32'(busy_a), 32'd1);
        tick();
        check("single_req_tog", 32'(req_a), 32'd1);
        repeat (4) tick();
        check("single_wait_busy", 32'(busy_a), 32'd1);
        check("single_wait_tx", 32'(txc_a), 32'd0);
        tick();
        check("single_idle", 32'(busy_a), 32'd0);
        check("single_tx", 32'(txc_a), 32'd1);

        // Round-robin with valid=1010, pointer just past requester 0
        src_data_a  = {3'd2, 3'd0, 3'd6, 3'd0};
        src_valid_a = 4'b1010;
        token_a(1, 3'd6, 1'b0);
        token_a(3, 3'd2, 1'b1);
        token_a(1, 3'd6, 1'b0);
        src_valid_a = 4'b0000;
        check("rr_tx", 32'(txc_a), 32'd4);

        // Asynchronous reset in the middle of WAIT with req_out high
        ack_en_a    = 1'b0;
        src_data_a  = 12'd3;
        src_valid_a = 4'b0001;
        tick();
        src_valid_a = 4'b0000;
        tick();
        check("mw_req", 32'(req_a), 32'd1);
        check("mw_busy", 32'(busy_a), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mw_rst_req", 32'(req_a), 32'd0);
        check("mw_rst_busy", 32'(busy_a), 32'd0);
        check("mw_rst_err", 32'(err_a), 32'd0);
        check("mw_rst_tx", 32'(txc_a), 32'd0);
        check("mw_rst_dout", 32'(dout_a), 32'd0);
        tick();
        rst      = 1'b0;
        ack_en_a = 1'b1;
        tick();

        // All four requesters valid continuously
        src_data_a  = {3'd4, 3'd3, 3'd2, 3'd1};
        src_valid_a = 4'b1111;
        token_a(0, 3'd1, 1'b1);
        token_a(1, 3'd2, 1'b0);
        token_a(2, 3'd3, 1'b1);
        token_a(3, 3'd4, 1'b0);
        token_a(0, 3'd1, 1'b1);
        src_valid_a = 4'b0000;
        check("all_tx", 32'(txc_a), 32'd5);

        // Timeout: no ack ever; err exactly 10 cycles after WAIT entry
        ack_en_a = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        src_data_a  = 12'd7;
        src_valid_a = 4'b0001;
        tick();
        tick();
        check("to_req", 32'(req_a), 32'd1);
        repeat (9) tick();
        check("to_err_early", 32'(err_a), 32'd0);
        check("to_busy_early", 32'(busy_a), 32'd1);
        tick();
        check("to_err", 32'(err_a), 32'd1);
        check("to_busy", 32'(busy_a), 32'd0);
        check("to_ready", 32'(src_ready_a), 32'h0);
        repeat (5) tick();
        check("to_err_hold", 32'(err_a), 32'd1);
        check("to_req_hold", 32'(req_a), 32'd1);
        check("to_dout_hold", 32'(dout_a), 32'd7);
        check("to_ready_hold", 32'(src_ready_a), 32'h0);
        check("to_tx", 32'(txc_a), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("to_rst_err", 32'(err_a), 32'd0);
        tick();
        rst         = 1'b0;
        src_valid_a = 4'b0000;
        ack_en_a    = 1'b1;
        tick();

        // Counter wrap on instance B: SETUP_CYC=3, CNTW=2
        exp_req_b   = 1'b0;
        src_data_b  = {3'd0, 3'd3, 3'd0, 3'd0};
        src_valid_b = 4'b0100;
        for (int t = 0; t < 5; t++) begin
            d = 3'(t + 3);
            #1;
            n = 0;
            while (src_ready_b == 4'b0000 && n < 40) begin
                tick();
                n++;
            end
            check("wr_ready", 32'(src_ready_b), 32'h4);
            tick();
            check("wr_d1", 32'(dout_b), 32'(d));
            tick();
            check("wr_d2", 32'(dout_b), 32'(d));
            tick();
            check("wr_d3", 32'(dout_b), 32'(d));
            check("wr_req_hold", 32'(req_b), 32'(exp_req_b));
            tick();
            exp_req_b = !exp_req_b;
            check("wr_req_tog", 32'(req_b), 32'(exp_req_b));
            check("wr_d4", 32'(dout_b), 32'(d));
            src_data_b[8:6] = d + 3'd1;
            tick();
            check("wr_frozen", 32'(dout_b), 32'(d));
            n = 0;
            while (busy_b && n < 40) begin
                tick();
                n++;
            end
            check("wr_idle", 32'(busy_b), 32'd0);
            check("wr_tx", 32'(txc_b), 32'((t + 1) % 4));
        end
        src_valid_b = 4'b0000;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hs_issue_arbiter.md
Name: hs_issue_arbiter

Overview:
- Clocked controller that shares one 2-phase (transition-signalled) bundled-data handshake pipeline between NREQ synchronous requesters.
- Arbitrates round-robin, launches one token at a time: latches data, waits a setup interval, toggles req_out, then waits for ack_in to match.
- Sits at the clocked/asynchronous boundary in front of the first pipeline stage; ack_in is asynchronous to clk.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 3, data width per token
- SETUP_CYC, 1, clk cycles data_out is stable before req_out toggles (1..7)
- TIMEOUT, 255, max WAIT cycles before error (1..65535)
- CNTW, 16, width of completed-token counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- src_valid  in  NREQ  requester i has a token
- src_data  in  NREQ*W  token data, requester i at bits [i*W +: W]
- src_ready  out  NREQ  one-hot acceptance strobe, combinational
- req_out  out  1  2-phase request to pipeline, registered
- ack_in  in  1  2-phase acknowledge from pipeline, asynchronous
- data_out  out  W  bundled data to pipeline, registered
- grant_id  out  clog2(NREQ)  requester owning current token
- busy  out  1  high in SETUP or WAIT
- err  out  1  sticky handshake timeout flag
- tx_count  out  CNTW  completed tokens, wraps

Behaviour:
- Reset (asynchronous, any state): state=IDLE, req_out=0, data_out=0, grant_id=0, rr pointer=0, sync flops=0, err=0, tx_count=0, counters=0. The pipeline is reset alongside so its ack phase is 0.
- ack_in passes a 2-flop synchronizer to ack_s. Handshake is complete when ack_s==req_out.
- IDLE: if any src_valid, grant the first valid index at or after rr pointer (circular). That cycle src_ready[g]=1 (all others 0), data_out<=src_data[g], grant_id<=g, go SETUP. No valid: src_ready=0, stay.
- SETUP: count SETUP_CYC cycles. On the last one, req_out<=~req_out and go WAIT. data_out is frozen from acceptance until the return to IDLE.
- WAIT: when ack_s==req_out, tx_count<=tx_count+1 (mod 2^CNTW), rr pointer<=(grant_id+1) mod NREQ, go IDLE. If TIMEOUT cycles elapse without a match, err<=1 and go ERR.
- ERR: terminal until rst. src_ready=0, req_out/data_out held, busy=0, err=1.
- Latency, SETUP_CYC=1: accept at cycle 0, req_out toggles visible at cycle 2. An ack toggle arriving before edge k is seen as ack_s at k+2. State is IDLE the cycle after the match. Minimum token period = SETUP_CYC + 4 cycles with an instant ack.
- src_ready never asserts outside IDLE. Requesters hold src_valid/src_data until accepted.
- Simultaneous valids: strict round-robin, no starvation. Max wait is NREQ-1 tokens.
- Early or glitching ack (ack_s!=req_out while IDLE or SETUP) is ignored. In WAIT only equality matters.
- rr pointer wraps NREQ-1 -> 0. tx_count wraps all-ones -> 0 with no flag.
- Timeout counter clears on entry to WAIT. A match on the same cycle the count reaches TIMEOUT counts as success.
- busy = (state==SETUP || state==WAIT).

Decomposition:
- Package hs_issue_pkg holds: state enum (IDLE, SETUP, WAIT, ERR) and helper function for clog2 width.
- One sub-module, sync2: 2-flop synchronizer with asynchronous active-high reset to 0. Instantiated for ack_in.
- Round-robin pick stays inline.

Test Plan:
- Reset mid-WAIT: rst pulse while req_out=1 -> req_out=0, state IDLE, err=0, tx_count=0 immediately, without waiting for clk.
- Single requester, NREQ=4: src_valid=0001, src_data[0]=3'b101, ack model echoes req after 3 cycles -> src_ready=0001 for 1 cycle, data_out=5, req_out 0->1 two cycles later, tx_count=1, back to IDLE.
- All four valid continuously, data i=i+1 -> grant order 0,1,2,3,0; data_out sequence 1,2,3,4,1; req_out toggles each token; tx_count=5.
- rr fairness: valid=1010 with pointer=0 -> grant 1, then grant 3, then grant 1.
- Timeout, TIMEOUT=10: ack never toggles -> err=1 exactly 10 cycles after WAIT entry, busy=0, src_ready stays 0 with valid high, held until rst.
- Wrap, CNTW=2, SETUP_CYC=3: 5 tokens -> tx_count 1,2,3,0,1. Each req_out toggle occurs 4 cycles after its src_ready, with data_out stable throughout.
